// File: rtl/watch_field_sel_cu.sv
// rtl/watch_field_sel_cu.sv - edit-field selector with cursor, inc/dec routing, blink and timeout
//
// Purpose: holds the watch VIEW/EDIT mode and a cursor over N_FIELDS digit
// fields, routes inc/dec pulses to the selected field only, produces the
// display blink phase and leaves EDIT after an inactivity timeout.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   i_mode         pulse: toggle VIEW/EDIT
//   i_digit_left   pulse: cursor +1 (toward more significant field)
//   i_digit_right  pulse: cursor -1
//   i_inc, i_dec   pulse: increment / decrement selected field
//   o_edit_active  1 while in EDIT
//   o_digit_pos    one-hot selected field in EDIT, zero in VIEW
//   o_inc, o_dec   registered one-hot edit pulses
//   o_blink        blink phase, 1 = field visible
//
// Optional build macro: WATCH_FIELD_SEL_NO_WRAP_EN (cursor saturates at the
// ends instead of wrapping).

module watch_field_sel_cu #(
    parameter int N_FIELDS  = 3,
    parameter int CLK_HZ    = 100_000_000,
    parameter int TIMEOUT_S = 10,
    parameter int BLINK_HZ  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_mode,
    input  logic                i_digit_left,
    input  logic                i_digit_right,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic                o_edit_active,
    output logic [N_FIELDS-1:0] o_digit_pos,
    output logic [N_FIELDS-1:0] o_inc,
    output logic [N_FIELDS-1:0] o_dec,
    output logic                o_blink
);

    localparam int IW          = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int TIMEOUT_CYC = CLK_HZ * TIMEOUT_S;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int BLINK_HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW          = $clog2(BLINK_HALF + 1);

    localparam logic [IW-1:0] IDX_MAX = IW'(N_FIELDS - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic {
        ST_VIEW = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_FIELDS-1:0] inc_q, inc_d;
    logic [N_FIELDS-1:0] dec_q, dec_d;
    logic                blink_q, blink_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;

    logic                nav;
    logic                any_pulse;
    logic [IW-1:0]       idx_nav;

    function automatic logic [N_FIELDS-1:0] onehot(input logic [IW-1:0] i);
        logic [N_FIELDS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << i;
    endfunction

    assign nav       = i_digit_left | i_digit_right;
    assign any_pulse = i_mode | nav | i_inc | i_dec;

    // Cursor after navigation; left has priority over right.
    always_comb begin
        idx_nav = idx_q;
`ifdef WATCH_FIELD_SEL_NO_WRAP_EN
        if (i_digit_left) begin
            if (idx_q != IDX_MAX) idx_nav = idx_q + IW'(1);
        end else if (i_digit_right) begin
            if (idx_q != '0) idx_nav = idx_q - IW'(1);
        end
`else
        if (i_digit_left) begin
            idx_nav = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end else if (i_digit_right) begin
            idx_nav = (idx_q == '0) ? IDX_MAX : idx_q - IW'(1);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        inc_d   = '0;
        dec_d   = '0;
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            ST_VIEW: begin
                // Idle display: field always visible, counters parked.
                idx_d   = '0;
                blink_d = 1'b1;
                bcnt_d  = '0;
                tcnt_d  = '0;
                if (i_mode) state_d = ST_EDIT;
            end
            ST_EDIT: begin
                if (i_mode) begin
                    state_d = ST_VIEW;
                    idx_d   = '0;
                    blink_d = 1'b1;
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                end else begin
                    idx_d = idx_nav;
                    // Pulses target the post-navigation cursor; simultaneous
                    // inc and dec cancel each other.
                    if (i_inc && !i_dec) inc_d = onehot(idx_nav);
                    if (i_dec && !i_inc) dec_d = onehot(idx_nav);

                    if (nav) begin
                        bcnt_d  = '0;
                        blink_d = 1'b1;
                    end else if (bcnt_q == BL_LAST) begin
                        bcnt_d  = '0;
                        blink_d = ~blink_q;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end

                    if (any_pulse) begin
                        tcnt_d = '0;
                    end else if (tcnt_q == TO_LAST) begin
                        state_d = ST_VIEW;
                        idx_d   = '0;
                        blink_d = 1'b1;
                        bcnt_d  = '0;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_VIEW;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_VIEW;
            idx_q   <= '0;
            inc_q   <= '0;
            dec_q   <= '0;
            blink_q <= 1'b1;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign o_edit_active = (state_q == ST_EDIT);
    assign o_digit_pos   = (state_q == ST_EDIT) ? onehot(idx_q) : '0;
    assign o_inc         = inc_q;
    assign o_dec         = dec_q;
    assign o_blink       = blink_q;

endmodule

// File: tb/tb_watch_field_sel_cu.sv
// tb/tb_watch_field_sel_cu.sv - scoreboard bench for watch_field_sel_cu

module tb_watch_field_sel_cu;

    logic       clk;
    logic       rst;
    logic       i_mode, i_digit_left, i_digit_right, i_inc, i_dec;
    logic       o_edit_active;
    logic [3:0] o_digit_pos, o_inc, o_dec;
    logic       o_blink;

    watch_field_sel_cu #(
        .N_FIELDS (4),
        .CLK_HZ   (100),
        .TIMEOUT_S(1),
        .BLINK_HZ (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mode       (i_mode),
        .i_digit_left (i_digit_left),
        .i_digit_right(i_digit_right),
        .i_inc        (i_inc),
        .i_dec        (i_dec),
        .o_edit_active(o_edit_active),
        .o_digit_pos  (o_digit_pos),
        .o_inc        (o_inc),
        .o_dec        (o_dec),
        .o_blink      (o_blink)
    );

    typedef struct {
        logic       edit;
        logic [3:0] pos;
        logic [3:0] inc;
        logic [3:0] dec;
        logic       blink;
        bit         cb;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic edit, input logic [3:0] pos,
                                input logic [3:0] inc, input logic [3:0] dec,
                                input logic blink, input bit cb, input string name);
        exp_t e;
        e.edit = edit; e.pos = pos; e.inc = inc; e.dec = dec;
        e.blink = blink; e.cb = cb; e.name = name;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic step(input logic r, input logic m, input logic l, input logic rt,
                        input logic in, input logic de, input exp_t e);
        @(negedge clk);
        rst = r; i_mode = m; i_digit_left = l; i_digit_right = rt;
        i_inc = in; i_dec = de;
        sb.push_back(e);
    endtask

    task automatic idle(input exp_t e);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    // Monitor: one queued expectation per clock edge, sampled 1 ns after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (o_edit_active !== e.edit) begin
                    n_fail++;
                    $display("FAIL %s edit: got %b want %b", e.name, o_edit_active, e.edit);
                end
                n_checks++;
                if (o_digit_pos !== e.pos) begin
                    n_fail++;
                    $display("FAIL %s pos: got %b want %b", e.name, o_digit_pos, e.pos);
                end
                n_checks++;
                if (o_inc !== e.inc) begin
                    n_fail++;
                    $display("FAIL %s inc: got %b want %b", e.name, o_inc, e.inc);
                end
                n_checks++;
                if (o_dec !== e.dec) begin
                    n_fail++;
                    $display("FAIL %s dec: got %b want %b", e.name, o_dec, e.dec);
                end
                if (e.cb) begin
                    n_checks++;
                    if (o_blink !== e.blink) begin
                        n_fail++;
                        $display("FAIL %s blink: got %b want %b", e.name, o_blink, e.blink);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; i_mode = 1'b0; i_digit_left = 1'b0; i_digit_right = 1'b0;
        i_inc = 1'b0; i_dec = 1'b0;

        // 1. reset, ignored pulses in VIEW, entry to EDIT
        step(1, 0, 0, 0, 0, 0, mk(0, 4'b0000, 0, 0, 1, 1, "rst0"));
        step(1, 0, 0, 0, 0, 0, mk(0, 4'b0000, 0, 0, 1, 1, "rst1"));
        idle(mk(0, 4'b0000, 0, 0, 1, 1, "view_idle"));
        step(0, 0, 1, 0, 1, 0, mk(0, 4'b0000, 0, 0, 1, 1, "view_ignore"));
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "enter"));

        // 2. navigation
`ifdef WATCH_FIELD_SEL_NO_WRAP_EN
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0010, 0, 0, 1, 1, "nav_l1"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0100, 0, 0, 1, 1, "nav_l2"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b1000, 0, 0, 1, 1, "nav_l3"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b1000, 0, 0, 1, 1, "nav_l_sat"));
        step(0, 0, 0, 1, 0, 0, mk(1, 4'b0100, 0, 0, 1, 1, "nav_r"));
        step(0, 0, 1, 1, 0, 0, mk(1, 4'b1000, 0, 0, 1, 1, "nav_lr"));
        step(0, 1, 0, 0, 0, 0, mk(0, 4'b0000, 0, 0, 1, 1, "nav_exit"));
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "nav_reenter"));
        step(0, 0, 0, 1, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "nav_r_sat"));
`else
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0010, 0, 0, 1, 1, "nav_l1"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0100, 0, 0, 1, 1, "nav_l2"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b1000, 0, 0, 1, 1, "nav_l3"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "nav_l_wrap"));
        step(0, 0, 0, 1, 0, 0, mk(1, 4'b1000, 0, 0, 1, 1, "nav_r_wrap"));
        step(0, 0, 1, 1, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "nav_lr"));
`endif

        // 3. field edit pulses (re-enter so idx starts at 0 in every build)
        step(0, 1, 0, 0, 0, 0, mk(0, 4'b0000, 0, 0, 1, 1, "ed_exit"));
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "ed_enter"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0010, 0, 0, 1, 1, "ed_l1"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0100, 0, 0, 1, 1, "ed_l2"));
        step(0, 0, 0, 0, 1, 0, mk(1, 4'b0100, 4'b0100, 0, 1, 1, "ed_inc"));
        idle(mk(1, 4'b0100, 0, 0, 1, 1, "ed_inc_1cyc"));
        step(0, 0, 0, 0, 0, 1, mk(1, 4'b0100, 0, 4'b0100, 1, 1, "ed_dec"));
        step(0, 0, 0, 0, 1, 1, mk(1, 4'b0100, 0, 0, 1, 1, "ed_incdec"));
        step(0, 0, 1, 0, 1, 0, mk(1, 4'b1000, 4'b1000, 0, 1, 1, "ed_nav_inc"));
        step(0, 1, 0, 0, 1, 0, mk(0, 4'b0000, 0, 0, 1, 1, "ed_mode_inc"));

        // 4a. timeout with no input, blink pattern checked along the way
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "to_enter"));
        for (int k = 1; k <= 99; k++)
            idle(mk(1, 4'b0001, 0, 0, ((k / 5) % 2) == 0, 1, "to_idle"));
        idle(mk(0, 4'b0000, 0, 0, 1, 1, "to_exit"));

        // 4b. timeout restarted by a pulse at cycle 60
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "to2_enter"));
        for (int k = 1; k <= 59; k++)
            idle(mk(1, 4'b0001, 0, 0, ((k / 5) % 2) == 0, 1, "to2_pre"));
        step(0, 0, 0, 0, 1, 0, mk(1, 4'b0001, 4'b0001, 0, 1, 1, "to2_pulse"));
        for (int k = 61; k <= 159; k++)
            idle(mk(1, 4'b0001, 0, 0, ((k / 5) % 2) == 0, 1, "to2_post"));
        idle(mk(0, 4'b0000, 0, 0, 1, 1, "to2_exit"));

        // 5. blink restart by navigation during the dark phase
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "bl_enter"));
        for (int k = 1; k <= 7; k++)
            idle(mk(1, 4'b0001, 0, 0, ((k / 5) % 2) == 0, 1, "bl_pre"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0010, 0, 0, 1, 1, "bl_nav"));
        for (int j = 1; j <= 10; j++)
            idle(mk(1, 4'b0010, 0, 0, ((j / 5) % 2) == 0, 1, "bl_post"));
        step(0, 1, 0, 0, 0, 0, mk(0, 4'b0000, 0, 0, 1, 1, "bl_exit"));

        // 6. reset mid-edit with a simultaneous inc pulse
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "rs_enter"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0010, 0, 0, 1, 1, "rs_l1"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b0100, 0, 0, 1, 1, "rs_l2"));
        step(0, 0, 1, 0, 0, 0, mk(1, 4'b1000, 0, 0, 1, 1, "rs_l3"));
        step(1, 0, 0, 0, 1, 0, mk(0, 4'b0000, 0, 0, 1, 1, "rs_abort"));
        idle(mk(0, 4'b0000, 0, 0, 1, 1, "rs_idle"));
        step(0, 1, 0, 0, 0, 0, mk(1, 4'b0001, 0, 0, 1, 1, "rs_reenter"));
        idle(mk(1, 4'b0001, 0, 0, 1, 1, "rs_hold"));

        @(negedge clk);
        i_mode = 0; i_digit_left = 0; i_digit_right = 0; i_inc = 0; i_dec = 0;
        stim_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
